valid_ready_receiver: RTL and testbench
=======================================

// Module: valid_ready_receiver
// PURPOSE
//  Sink end of the valid/ready link driven by transmitter. Accepts words on
//  valid&&ready, buffers them in a DEPTH-entry FIFO, and presents them to a
//  downstream consumer on a second valid/ready port. Throttles the link via
//  registered ready, counts accepted words, and flags valid-withdrawal violations.
// PARAMETERS
//  DATA_WIDTH  8   width of data on both ports
//  DEPTH       4   FIFO entries; power of 2, >= 2
//  CNT_WIDTH   32  width of recv_count; wraps modulo 2**CNT_WIDTH
// PORTS
//  clk         in   1           rising-edge clock
//  rst         in   1           asynchronous reset, active-high
//  valid       in   1           link: transmitter has a word
//  data        in   DATA_WIDTH  link: word; sampled only when valid&&ready
//  ready       out  1           link: receiver accepts this cycle (registered)
//  hold        in   1           force ready low from next cycle (flow-control test)
//  out_valid   out  1           consumer: head word available
//  out_data    out  DATA_WIDTH  consumer: head word; 0 when out_valid=0
//  out_ready   in   1           consumer: takes head word this cycle
//  recv_count  out  CNT_WIDTH   total words accepted since reset
//  level       out  $clog2(DEPTH)+1  current FIFO occupancy
//  proto_err   out  1           sticky: valid dropped while ready=0
// BEHAVIOUR
//  - Reset (async assert, sync release): ready=0, out_valid=0, out_data=0,
//    recv_count=0, level=0, proto_err=0; FIFO contents discarded, pointers 0.
//  - push = valid && ready; pop = out_valid && out_ready. Both sampled at posedge.
//  - level_next = level + push - pop; push and pop together leave level unchanged.
//  - ready register: ready <= !hold && (level_next < DEPTH). First ready=1 is
//    the first posedge after rst release. Since ready reflects level_next, a
//    push can never overflow; ready=1 at level=DEPTH-1 may coincide with a push
//    that fills the FIFO, after which ready is already 0.
//  - Full (level=DEPTH): ready=0; a pop in that cycle raises ready next cycle.
//  - Empty (level=0): out_valid=0, out_data=0. No bypass: a word pushed at
//    edge N is visible on out_valid/out_data after edge N (latency 1 cycle).
//  - out_valid = (level != 0); out_data = mem[rd_ptr] combinationally.
//  - Pointers: $clog2(DEPTH) bits, wrap naturally at DEPTH-1 -> 0.
//  - recv_count += 1 on every push; wraps from all-ones to 0, no saturation.
//  - proto_err: track pending = valid && !ready at each edge; if pending was 1
//    and valid is now 0, set proto_err; cleared only by rst.
//  - hold asserted mid-burst: ready falls at next edge; words already accepted
//    continue to drain to consumer unaffected.
//  - Reset mid-operation: all of the above return to reset values immediately;
//    in-flight word on the link is not accepted.
//  - data sampled only on push; X/Z on data when not pushing is ignored.
// STRUCTURE
//  - Package vr_pkg: localparam helpers for pointer/level widths (function
//    level_width(int depth)), typedef for status {level, proto_err}.
//  - Sub-module vr_fifo #(DATA_WIDTH, DEPTH): storage, pointers, level,
//    push/pop, head output. Top adds ready register, counter, proto_err.
// TESTING
//  1. rst pulse mid-stream -> ready/out_valid/level/recv_count/proto_err all 0
//     asynchronously; ready=1 one edge after release.
//  2. out_ready=0, valid=1 with data 0x11,0x22,0x33,0x44 (DEPTH=4) -> level=4,
//     ready=0 after 4th push, 5th word 0x55 held off; recv_count=4.
//  3. From full, out_ready=1 one cycle -> out_data=0x11 popped, ready=1 next
//     edge, 0x55 accepted; then drain yields 0x22,0x33,0x44,0x55 in order.
//  4. Continuous valid and out_ready=1 for 20 words -> level stays <= 1, one
//     word per cycle, out order == in order, recv_count=20.
//  5. hold=1 with valid=1 -> ready=0 next edge, no pushes, proto_err stays 0;
//     then drop valid while ready=0 -> proto_err=1 and remains set.
//  6. Force recv_count to 2**CNT_WIDTH-1 (CNT_WIDTH=4: 15 words) then push
//     one more -> recv_count=0.

Source files
------------

// File: rtl/vr_pkg.sv
// Shared width helpers and status typedef for the valid/ready receiver slice.
package vr_pkg;

    function automatic int ptr_width(input int depth);
        return $clog2(depth);
    endfunction

    // One extra bit so a completely full FIFO (level == DEPTH) is representable.
    function automatic int level_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    localparam int DEFAULT_DEPTH = 4;

    typedef struct packed {
        logic [level_width(DEFAULT_DEPTH)-1:0] level;
        logic                                  proto_err;
    } vr_status_t;

endpackage

// File: rtl/vr_fifo.sv
// DEPTH-entry FIFO with occupancy tracking and a zeroed head word while empty.
module vr_fifo
    import vr_pkg::*;
#(
    parameter  int DATA_WIDTH = 8,
    parameter  int DEPTH      = 4,
    localparam int PW         = ptr_width(DEPTH),
    localparam int LW         = level_width(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] push_data,
    output logic [DATA_WIDTH-1:0] head_data,
    output logic                  head_valid,
    output logic [LW-1:0]         level,
    output logic [LW-1:0]         level_next
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]         level_q, level_d;

    // Pointers are exactly log2(DEPTH) bits, so they wrap to 0 on their own.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        level_d = level_q + LW'(push) - LW'(pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    assign head_valid = (level_q != '0);
    assign head_data  = head_valid ? mem_q[rd_ptr_q] : '0;
    assign level      = level_q;
    assign level_next = level_d;

endmodule

// File: rtl/valid_ready_receiver.sv
// Link sink: registered ready throttling, FIFO buffering toward the consumer,
// an accepted-word counter and a sticky valid-withdrawal flag.
module valid_ready_receiver
    import vr_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          valid,
    input  logic [DATA_WIDTH-1:0]         data,
    output logic                          ready,
    input  logic                          hold,
    output logic                          out_valid,
    output logic [DATA_WIDTH-1:0]         out_data,
    input  logic                          out_ready,
    output logic [CNT_WIDTH-1:0]          recv_count,
    output logic [level_width(DEPTH)-1:0] level,
    output logic                          proto_err
);

    localparam int LW = level_width(DEPTH);

    logic                 ready_q, ready_d;
    logic [CNT_WIDTH-1:0] recv_count_q, recv_count_d;
    logic                 pending_q, pending_d;
    logic                 proto_err_q, proto_err_d;
    logic                 push, pop;
    logic                 fifo_valid;
    logic [LW-1:0]        fifo_level, fifo_level_next;

    vr_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .pop        (pop),
        .push_data  (data),
        .head_data  (out_data),
        .head_valid (fifo_valid),
        .level      (fifo_level),
        .level_next (fifo_level_next)
    );

    // Ready looks at next-cycle occupancy, so an accepted word can never overflow.
    always_comb begin
        push         = valid && ready_q;
        pop          = fifo_valid && out_ready;
        ready_d      = !hold && (fifo_level_next < LW'(DEPTH));
        recv_count_d = recv_count_q + CNT_WIDTH'(push);
        pending_d    = valid && !ready_q;
        proto_err_d  = proto_err_q || (pending_q && !valid);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_q      <= 1'b0;
            recv_count_q <= '0;
            pending_q    <= 1'b0;
            proto_err_q  <= 1'b0;
        end else begin
            ready_q      <= ready_d;
            recv_count_q <= recv_count_d;
            pending_q    <= pending_d;
            proto_err_q  <= proto_err_d;
        end
    end

    assign ready      = ready_q;
    assign out_valid  = fifo_valid;
    assign recv_count = recv_count_q;
    assign level      = fifo_level;
    assign proto_err  = proto_err_q;

endmodule

// File: tb/tb_valid_ready_receiver.sv
// Scoreboard bench for valid_ready_receiver (DEPTH=4, CNT_WIDTH=4 so wrap is reachable).
module tb_valid_ready_receiver;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       valid = 1'b0;
    logic [7:0] data = 8'h00;
    logic       ready;
    logic       hold = 1'b0;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready = 1'b0;
    logic [3:0] recv_count;
    logic [2:0] level;
    logic       proto_err;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] exp_q[$];
    int         m_level;
    logic [3:0] m_count;
    logic       m_ready, m_pending, m_proto;

    valid_ready_receiver #(.DATA_WIDTH(8), .DEPTH(4), .CNT_WIDTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .valid      (valid),
        .data       (data),
        .ready      (ready),
        .hold       (hold),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .recv_count (recv_count),
        .level      (level),
        .proto_err  (proto_err)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        exp_q.delete();
        m_level   = 0;
        m_count   = 4'd0;
        m_ready   = 1'b0;
        m_pending = 1'b0;
        m_proto   = 1'b0;
    endtask

    // Drives one cycle, advances the reference model, returns any popped word.
    task automatic tick(input logic v, input logic [7:0] d, input logic h, input logic ordy,
                        output logic popped, output logic [7:0] got, output logic [7:0] want);
        logic do_push, do_pop;
        valid = v; data = d; hold = h; out_ready = ordy;
        #1;
        do_push = v && m_ready;
        do_pop  = (m_level != 0) && ordy;
        popped  = do_pop;
        got     = out_data;
        want    = 8'h00;
        if (do_push) exp_q.push_back(d);
        if (do_pop && exp_q.size() > 0) want = exp_q.pop_front();
        m_level   = m_level + int'(do_push) - int'(do_pop);
        m_count   = m_count + 4'(do_push);
        m_proto   = m_proto | (m_pending && !v);
        m_pending = v && !m_ready;
        m_ready   = !h && (m_level < 4);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic p; logic [7:0] g, w;
        tick(1'b1, 8'hA1, 1'b0, 1'b0, p, g, w);
        tick(1'b1, 8'hA2, 1'b0, 1'b0, p, g, w);
        tick(1'b1, 8'hA3, 1'b0, 1'b0, p, g, w);
        vectors++;
        if (level !== 3'(m_level)) begin miscompares++; $display("[TB] FAIL pre_reset_level: got %0d expected %0d", level, m_level); end
        valid = 1'b1; data = 8'hEE;
        #2 rst = 1'b1;
        #1;
        model_reset();
        vectors++; if (ready !== 1'b0)      begin miscompares++; $display("[TB] FAIL rst_ready: got %b expected 0", ready); end
        vectors++; if (out_valid !== 1'b0)  begin miscompares++; $display("[TB] FAIL rst_out_valid: got %b expected 0", out_valid); end
        vectors++; if (out_data !== 8'h00)  begin miscompares++; $display("[TB] FAIL rst_out_data: got %h expected 00", out_data); end
        vectors++; if (level !== 3'd0)      begin miscompares++; $display("[TB] FAIL rst_level: got %0d expected 0", level); end
        vectors++; if (recv_count !== 4'd0) begin miscompares++; $display("[TB] FAIL rst_count: got %0d expected 0", recv_count); end
        vectors++; if (proto_err !== 1'b0)  begin miscompares++; $display("[TB] FAIL rst_proto_err: got %b expected 0", proto_err); end
        @(posedge clk); #1;
        vectors++; if (level !== 3'd0) begin miscompares++; $display("[TB] FAIL rst_inflight_level: got %0d expected 0", level); end
        rst = 1'b0;
        tick(1'b0, 8'h00, 1'b0, 1'b0, p, g, w);
        vectors++; if (ready !== 1'b1) begin miscompares++; $display("[TB] FAIL rst_release_ready: got %b expected 1", ready); end
    endtask

    task automatic test_fill();
        logic p; logic [7:0] g, w;
        logic [7:0] words [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, words[i], 1'b0, 1'b0, p, g, w);
            vectors++;
            if (level !== 3'(i + 1)) begin miscompares++; $display("[TB] FAIL fill_level: got %0d expected %0d", level, i + 1); end
        end
        vectors++; if (ready !== 1'b0) begin miscompares++; $display("[TB] FAIL fill_ready_full: got %b expected 0", ready); end
        for (int i = 0; i < 2; i++) begin
            tick(1'b1, 8'h55, 1'b0, 1'b0, p, g, w);
            vectors++;
            if (level !== 3'd4 || ready !== 1'b0) begin miscompares++; $display("[TB] FAIL fill_held_off: got level %0d ready %b expected level 4 ready 0", level, ready); end
        end
        vectors++; if (recv_count !== 4'd4) begin miscompares++; $display("[TB] FAIL fill_count: got %0d expected 4", recv_count); end
        vectors++; if (out_data !== 8'h11) begin miscompares++; $display("[TB] FAIL fill_head: got %h expected 11", out_data); end
    endtask

    task automatic test_drain();
        logic p; logic [7:0] g, w;
        tick(1'b1, 8'h55, 1'b0, 1'b1, p, g, w);
        vectors++; if (!p || g !== 8'h11) begin miscompares++; $display("[TB] FAIL drain_first_pop: got %h expected 11", g); end
        vectors++; if (ready !== 1'b1 || level !== 3'd3) begin miscompares++; $display("[TB] FAIL drain_ready_back: got ready %b level %0d expected ready 1 level 3", ready, level); end
        tick(1'b1, 8'h55, 1'b0, 1'b0, p, g, w);
        vectors++; if (level !== 3'd4 || recv_count !== 4'd5) begin miscompares++; $display("[TB] FAIL drain_accept_55: got level %0d count %0d expected level 4 count 5", level, recv_count); end
        for (int i = 0; i < 6 && m_level > 0; i++) begin
            tick(1'b0, 8'h00, 1'b0, 1'b1, p, g, w);
            vectors++;
            if (g !== w) begin miscompares++; $display("[TB] FAIL drain_order: got %h expected %h", g, w); end
        end
        vectors++; if (out_valid !== 1'b0 || out_data !== 8'h00 || level !== 3'd0) begin miscompares++; $display("[TB] FAIL drain_empty: got valid %b data %h level %0d expected 0 00 0", out_valid, out_data, level); end
    endtask

    task automatic test_back_to_back();
        logic p; logic [7:0] g, w;
        for (int i = 0; i < 21; i++) begin
            tick(i < 20, 8'(8'hB0 + i), 1'b0, 1'b1, p, g, w);
            if (p) begin
                vectors++;
                if (g !== w) begin miscompares++; $display("[TB] FAIL stream_order: got %h expected %h", g, w); end
            end
            vectors++;
            if (level > 3'd1 || level !== 3'(m_level)) begin miscompares++; $display("[TB] FAIL stream_level: got %0d expected %0d (max 1)", level, m_level); end
        end
        vectors++; if (recv_count !== m_count) begin miscompares++; $display("[TB] FAIL stream_count: got %0d expected %0d", recv_count, m_count); end
        vectors++; if (exp_q.size() != 0 || out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL stream_leftover: got out_valid %b expected 0 with %0d queued", out_valid, exp_q.size()); end
    endtask

    task automatic test_hold_proto();
        logic p; logic [7:0] g, w;
        tick(1'b0, 8'h00, 1'b1, 1'b0, p, g, w);
        vectors++; if (ready !== 1'b0) begin miscompares++; $display("[TB] FAIL hold_ready: got %b expected 0", ready); end
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 8'h66, 1'b1, 1'b0, p, g, w);
            vectors++;
            if (level !== 3'd0 || proto_err !== 1'b0 || ready !== 1'b0) begin miscompares++; $display("[TB] FAIL hold_no_push: got level %0d proto %b ready %b expected 0 0 0", level, proto_err, ready); end
        end
        tick(1'b0, 8'h00, 1'b1, 1'b0, p, g, w);
        vectors++; if (proto_err !== 1'b1 || m_proto !== 1'b1) begin miscompares++; $display("[TB] FAIL proto_set: got %b expected 1", proto_err); end
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 8'h00, 1'b0, 1'b0, p, g, w);
            vectors++;
            if (proto_err !== m_proto || ready !== m_ready) begin miscompares++; $display("[TB] FAIL proto_sticky: got proto %b ready %b expected %b %b", proto_err, ready, m_proto, m_ready); end
        end
    endtask

    task automatic test_count_wrap();
        logic p; logic [7:0] g, w;
        #3 rst = 1'b1;
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        tick(1'b0, 8'h00, 1'b0, 1'b0, p, g, w);
        for (int i = 0; i < 15; i++) begin
            tick(1'b1, 8'(i), 1'b0, 1'b1, p, g, w);
            if (p) begin
                vectors++;
                if (g !== w) begin miscompares++; $display("[TB] FAIL wrap_order: got %h expected %h", g, w); end
            end
        end
        vectors++; if (recv_count !== 4'd15) begin miscompares++; $display("[TB] FAIL wrap_count_max: got %0d expected 15", recv_count); end
        tick(1'b1, 8'hF0, 1'b0, 1'b1, p, g, w);
        vectors++; if (recv_count !== 4'd0 || m_count !== 4'd0) begin miscompares++; $display("[TB] FAIL wrap_count_zero: got %0d expected 0", recv_count); end
        vectors++; if (proto_err !== 1'b0) begin miscompares++; $display("[TB] FAIL wrap_proto_cleared: got %b expected 0", proto_err); end
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        test_reset();
        test_fill();
        test_drain();
        test_back_to_back();
        test_hold_proto();
        test_count_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
